l2_arbiter_rr: RTL and testbench

Parametrised N-port arbiter that multiplexes cache-line requests from several L1 clients (I-cache, D-cache, and future clients such as a prefetcher) onto the single L2 cache port. It grants one client at a time with round-robin or fixed priority and latches that client's address, write data and command for the whole transaction. It drives explicit L2 read/write strobes and returns the response only to the granted client. It sits between the L1 caches and the L2 cache in the memory hierarchy.

---
 rtl/lc3b_types.sv | 14 +
 rtl/l2_arbiter_rr_if.sv | 40 ++++
 rtl/rr_select.sv | 36 +++
 rtl/l2_arbiter_rr.sv | 94 +++++++++
 tb/tb_l2_arbiter_rr.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types, plus the L2 arbiter constants and state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int unsigned L2_ARB_MAX_PORTS = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/l2_arbiter_rr_if.sv
// Client-side request bus and L2-side port of the L2 arbiter, bundled as one interface.
interface l2_arbiter_rr_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    localparam int IDW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]            req_resp;

    logic [LINE_WIDTH-1:0]           L2_rdata;
    logic                            L2_resp;
    logic                            L2_read;
    logic                            L2_write;
    logic [ADDR_WIDTH-1:0]           L2_address;
    logic [LINE_WIDTH-1:0]           L2_wdata;

    logic                            grant_valid;
    logic [IDW-1:0]                  grant_id;

    // Arbiter side.
    modport slave (
        input  req_read, req_write, req_address, req_wdata, L2_rdata, L2_resp,
        output req_rdata, req_resp, L2_read, L2_write, L2_address, L2_wdata,
               grant_valid, grant_id
    );

    // Environment side: L1 clients plus the L2 cache.
    modport master (
        output req_read, req_write, req_address, req_wdata, L2_rdata, L2_resp,
        input  req_rdata, req_resp, L2_read, L2_write, L2_address, L2_wdata,
               grant_valid, grant_id
    );

endinterface

// File: rtl/rr_select.sv
// Combinational winner picker: first requester at/after rr_ptr (mode=1) or lowest index (mode=0).
module rr_select
    import lc3b_types::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         requests,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
    input  logic                         mode,
    output logic [$clog2(NUM_PORTS)-1:0] winner,
    output logic                         any_req
);
    localparam int IDW = $clog2(NUM_PORTS);

    always_comb begin
        int unsigned base;
        int unsigned idx;
        logic [IDW-1:0] sel;
        winner  = '0;
        any_req = 1'b0;
        base    = mode ? int'(rr_ptr) : 0;
        idx     = 0;
        sel     = '0;
        // Scan NUM_PORTS candidates starting at base, wrapping without a modulo.
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = base + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            sel = IDW'(idx);
            if (!any_req && requests[sel]) begin
                any_req = 1'b1;
                winner  = sel;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter_rr.sv
// N-port L1-to-L2 arbiter: grants one client, latches its request, holds it until L2_resp.
module l2_arbiter_rr
    import lc3b_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int RR_MODE    = 1
) (
    input logic          clk,
    input logic          rst,
    l2_arbiter_rr_if.slave bus
);
    localparam int IDW = $clog2(NUM_PORTS);

    arb_state_t            state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant_id_q;
    logic                  read_q;
    logic                  write_q;
    logic                  grant_valid_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic [NUM_PORTS-1:0]  requests;
    logic [IDW-1:0]        winner;
    logic                  any_req;
    logic [NUM_PORTS-1:0]  resp_vec;

    assign requests = bus.req_read | bus.req_write;

    rr_select #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_select (
        .requests(requests),
        .rr_ptr  (rr_ptr),
        .mode    (RR_MODE != 0),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            grant_id_q    <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            grant_valid_q <= 1'b0;
            address_q     <= '0;
            wdata_q       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        state         <= ARB_BUSY;
                        grant_id_q    <= winner;
                        address_q     <= bus.req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q       <= bus.req_wdata[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
                        // Read and write together is illegal; the write is honoured.
                        write_q       <= bus.req_write[winner];
                        read_q        <= ~bus.req_write[winner];
                        grant_valid_q <= 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (bus.L2_resp) begin
                        state         <= ARB_IDLE;
                        read_q        <= 1'b0;
                        write_q       <= 1'b0;
                        grant_valid_q <= 1'b0;
                        rr_ptr        <= (grant_id_q == IDW'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        resp_vec = '0;
        if (state == ARB_BUSY && bus.L2_resp) resp_vec[grant_id_q] = 1'b1;
    end

    assign bus.req_resp    = resp_vec;
    assign bus.req_rdata   = bus.L2_rdata;
    assign bus.L2_read     = read_q;
    assign bus.L2_write    = write_q;
    assign bus.L2_address  = address_q;
    assign bus.L2_wdata    = wdata_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Directed bench for l2_arbiter_rr: 2-port round-robin, 4-port round-robin, 4-port fixed priority.
module tb_l2_arbiter_rr;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    l2_arbiter_rr_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) bus2 ();
    l2_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) bus4r ();
    l2_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) bus4f ();

    l2_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    l2_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1))
        u_dut4r (.clk(clk), .rst(rst), .bus(bus4r));
    l2_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0))
        u_dut4f (.clk(clk), .rst(rst), .bus(bus4f));

    lc3b_line rdata_dead;
    lc3b_line wdata_p1;
    lc3b_line wdata_p0;

    // Every slot starts at a falling edge; inputs change there, outputs are checked #1 later.
    task automatic slot();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.req_read = 2'b11;
        slot(); slot(); #1;
        checks++; if (bus2.grant_valid !== 1'b0) $display("FAIL rst_gv: got %b want 0", bus2.grant_valid); else passes++;
        checks++; if ({bus2.L2_read, bus2.L2_write} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {bus2.L2_read, bus2.L2_write}); else passes++;
        checks++; if (bus2.L2_address !== 16'h0 || bus2.L2_wdata !== '0) $display("FAIL rst_latch: addr=%h wdata=%h want 0", bus2.L2_address, bus2.L2_wdata); else passes++;
        checks++; if (bus2.grant_id !== 1'b0 || bus2.req_resp !== 2'b00) $display("FAIL rst_id_resp: id=%b resp=%b want 0/00", bus2.grant_id, bus2.req_resp); else passes++;
        checks++; if (bus4r.grant_valid !== 1'b0 || bus4f.grant_valid !== 1'b0) $display("FAIL rst_gv4: got %b%b want 00", bus4r.grant_valid, bus4f.grant_valid); else passes++;
        bus2.req_read = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        slot();
        bus2.req_read = 2'b10;
        bus2.req_address = {16'h1230, 16'h0000};
        #1;
        checks++; if (bus2.L2_read !== 1'b0) $display("FAIL sr_n: L2_read=%b want 0", bus2.L2_read); else passes++;
        for (int c = 1; c <= 2; c++) begin
            slot(); #1;
            checks++; if (bus2.L2_read !== 1'b1 || bus2.L2_address !== 16'h1230 || bus2.req_resp !== 2'b00)
                $display("FAIL sr_busy%0d: rd=%b addr=%h resp=%b want 1/1230/00", c, bus2.L2_read, bus2.L2_address, bus2.req_resp);
            else passes++;
        end
        slot();
        bus2.L2_resp = 1'b1;
        bus2.L2_rdata = rdata_dead;
        #1;
        checks++; if (bus2.req_resp !== 2'b10 || bus2.L2_read !== 1'b1 || bus2.grant_id !== 1'b1) $display("FAIL sr_resp: resp=%b rd=%b id=%b want 10/1/1", bus2.req_resp, bus2.L2_read, bus2.grant_id); else passes++;
        checks++; if (bus2.req_rdata !== rdata_dead) $display("FAIL sr_rdata: got %h want %h", bus2.req_rdata, rdata_dead); else passes++;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_read = 2'b00;
        #1;
        checks++; if (bus2.L2_read !== 1'b0 || bus2.grant_valid !== 1'b0 || bus2.req_resp !== 2'b00) $display("FAIL sr_after: rd=%b gv=%b resp=%b want 0/0/00", bus2.L2_read, bus2.grant_valid, bus2.req_resp); else passes++;
        slot(); #1;
        checks++; if (bus2.grant_valid !== 1'b0) $display("FAIL sr_nodup: gv=%b want 0", bus2.grant_valid); else passes++;
    endtask

    task automatic test_simultaneous();
        slot();
        bus2.req_read  = 2'b01;
        bus2.req_write = 2'b10;
        bus2.req_address = {16'h0200, 16'h0100};
        bus2.req_wdata = {wdata_p1, 128'h0};
        slot();
        bus2.L2_resp = 1'b1;
        #1;
        checks++; if (bus2.grant_id !== 1'b0 || bus2.L2_read !== 1'b1 || bus2.L2_address !== 16'h0100) $display("FAIL sim_first: id=%b rd=%b addr=%h want 0/1/0100", bus2.grant_id, bus2.L2_read, bus2.L2_address); else passes++;
        checks++; if (bus2.req_resp !== 2'b01) $display("FAIL sim_resp0: got %b want 01", bus2.req_resp); else passes++;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_read = 2'b00;
        #1;
        checks++; if (bus2.L2_read !== 1'b0 || bus2.L2_write !== 1'b0 || bus2.grant_valid !== 1'b0) $display("FAIL sim_bubble: rd=%b wr=%b gv=%b want 000", bus2.L2_read, bus2.L2_write, bus2.grant_valid); else passes++;
        slot(); #1;
        checks++; if (bus2.L2_write !== 1'b1 || bus2.L2_read !== 1'b0 || bus2.grant_id !== 1'b1) $display("FAIL sim_second: wr=%b rd=%b id=%b want 1/0/1", bus2.L2_write, bus2.L2_read, bus2.grant_id); else passes++;
        checks++; if (bus2.L2_address !== 16'h0200 || bus2.L2_wdata !== wdata_p1) $display("FAIL sim_wlatch: addr=%h wdata=%h want 0200/%h", bus2.L2_address, bus2.L2_wdata, wdata_p1); else passes++;
        slot();
        bus2.L2_resp = 1'b1;
        #1;
        checks++; if (bus2.req_resp !== 2'b10) $display("FAIL sim_resp1: got %b want 10", bus2.req_resp); else passes++;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_write = 2'b00;
    endtask

    task automatic test_addr_hold();
        slot();
        bus2.req_read = 2'b01;
        bus2.req_address = {16'h0000, 16'h0400};
        slot(); #1;
        checks++; if (bus2.L2_address !== 16'h0400 || bus2.grant_id !== 1'b0) $display("FAIL ah_grant: addr=%h id=%b want 0400/0", bus2.L2_address, bus2.grant_id); else passes++;
        bus2.req_address = {16'h0000, 16'h0800};
        slot(); #1;
        checks++; if (bus2.L2_address !== 16'h0400) $display("FAIL ah_hold: addr=%h want 0400", bus2.L2_address); else passes++;
        slot();
        bus2.L2_resp = 1'b1;
        #1;
        checks++; if (bus2.L2_address !== 16'h0400 || bus2.req_resp !== 2'b01) $display("FAIL ah_resp: addr=%h resp=%b want 0400/01", bus2.L2_address, bus2.req_resp); else passes++;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_read = 2'b00;
    endtask

    task automatic test_rw_conflict();
        slot();
        bus2.req_read  = 2'b10;
        bus2.req_write = 2'b10;
        bus2.req_address = {16'h0ABC, 16'h0000};
        bus2.req_wdata = {wdata_p0, 128'h0};
        slot(); #1;
        checks++; if (bus2.L2_write !== 1'b1 || bus2.L2_read !== 1'b0 || bus2.L2_wdata !== wdata_p0) $display("FAIL rw_writewins: wr=%b rd=%b wdata=%h want 1/0/%h", bus2.L2_write, bus2.L2_read, bus2.L2_wdata, wdata_p0); else passes++;
        bus2.L2_resp = 1'b1;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_read  = 2'b00;
        bus2.req_write = 2'b00;
    endtask

    task automatic test_reset_busy();
        // Serve port 0 so the round-robin pointer moves to port 1.
        slot();
        bus2.req_read = 2'b01;
        slot();
        bus2.L2_resp = 1'b1;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_read = 2'b11;
        slot(); #1;
        checks++; if (bus2.grant_id !== 1'b1 || bus2.grant_valid !== 1'b1) $display("FAIL rb_rrgrant: id=%b gv=%b want 1/1", bus2.grant_id, bus2.grant_valid); else passes++;
        rst = 1'b1;
        bus2.req_read = 2'b00;
        slot();
        rst = 1'b0;
        bus2.L2_resp = 1'b1;
        #1;
        checks++; if (bus2.L2_read !== 1'b0 || bus2.L2_write !== 1'b0 || bus2.grant_valid !== 1'b0) $display("FAIL rb_strobes: rd=%b wr=%b gv=%b want 000", bus2.L2_read, bus2.L2_write, bus2.grant_valid); else passes++;
        checks++; if (bus2.req_resp !== 2'b00) $display("FAIL rb_resp: got %b want 00", bus2.req_resp); else passes++;
        slot();
        bus2.L2_resp = 1'b0;
        bus2.req_read = 2'b11;
        slot(); #1;
        checks++; if (bus2.grant_id !== 1'b0 || bus2.grant_valid !== 1'b1) $display("FAIL rb_restart: id=%b gv=%b want 0/1", bus2.grant_id, bus2.grant_valid); else passes++;
        bus2.req_read = 2'b00;
        bus2.L2_resp = 1'b1;
        slot();
        bus2.L2_resp = 1'b0;
    endtask

    task automatic test_idle_resp();
        slot();
        bus2.L2_resp = 1'b1;
        #1;
        checks++; if (bus2.req_resp !== 2'b00 || bus2.grant_valid !== 1'b0) $display("FAIL ir_resp: resp=%b gv=%b want 00/0", bus2.req_resp, bus2.grant_valid); else passes++;
        slot();
        bus2.L2_resp = 1'b0;
        #1;
        checks++; if (bus2.grant_valid !== 1'b0 || bus2.L2_read !== 1'b0 || bus2.L2_write !== 1'b0) $display("FAIL ir_state: gv=%b rd=%b wr=%b want 000", bus2.grant_valid, bus2.L2_read, bus2.L2_write); else passes++;
    endtask

    task automatic test_rr4();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        slot();
        bus4r.req_read = 4'hF;
        bus4r.req_address = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        for (int t = 0; t < 5; t++) begin
            slot();
            bus4r.L2_resp = 1'b1;
            #1;
            checks++; if (bus4r.grant_valid !== 1'b1 || bus4r.grant_id !== 2'(exp_id[t]) || bus4r.L2_address !== 16'(16'h1000 + exp_id[t]))
                $display("FAIL rr4_grant%0d: gv=%b id=%0d addr=%h want 1/%0d/%h", t, bus4r.grant_valid, bus4r.grant_id, bus4r.L2_address, exp_id[t], 16'h1000 + exp_id[t]);
            else passes++;
            checks++; if (bus4r.req_resp !== 4'(1 << exp_id[t])) $display("FAIL rr4_resp%0d: got %b want %b", t, bus4r.req_resp, 4'(1 << exp_id[t])); else passes++;
            slot();
            bus4r.L2_resp = 1'b0;
            if (t == 4) bus4r.req_read = 4'h0;
        end
    endtask

    task automatic test_fixed4();
        slot();
        bus4f.req_read = 4'hF;
        for (int t = 0; t < 3; t++) begin
            slot();
            bus4f.L2_resp = 1'b1;
            #1;
            checks++; if (bus4f.grant_valid !== 1'b1 || bus4f.grant_id !== 2'd0 || bus4f.req_resp !== 4'b0001)
                $display("FAIL fx4_grant%0d: gv=%b id=%0d resp=%b want 1/0/0001", t, bus4f.grant_valid, bus4f.grant_id, bus4f.req_resp);
            else passes++;
            slot();
            bus4f.L2_resp = 1'b0;
            if (t == 2) bus4f.req_read = 4'h0;
        end
    endtask

    initial begin
        rdata_dead = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        wdata_p1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        wdata_p0   = 128'hA5A5_0000_FFFF_5A5A_1234_5678_9ABC_DEF0;
        bus2.req_read = '0;  bus2.req_write = '0;  bus2.req_address = '0;  bus2.req_wdata = '0;
        bus2.L2_rdata = '0;  bus2.L2_resp = 1'b0;
        bus4r.req_read = '0; bus4r.req_write = '0; bus4r.req_address = '0; bus4r.req_wdata = '0;
        bus4r.L2_rdata = '0; bus4r.L2_resp = 1'b0;
        bus4f.req_read = '0; bus4f.req_write = '0; bus4f.req_address = '0; bus4f.req_wdata = '0;
        bus4f.L2_rdata = '0; bus4f.L2_resp = 1'b0;

        test_reset();
        test_single_read();
        test_simultaneous();
        test_addr_hold();
        test_rw_conflict();
        test_reset_busy();
        test_idle_resp();
        test_rr4();
        test_fixed4();

        slot();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
